// File: rtl/vm_pkg.sv
// Shared definitions for the vending front-end: coin and product codes,
// coin values, the accumulator state encoding and the default credit width.
package vm_pkg;

    localparam int CW_DEFAULT = 5;

    typedef enum logic [1:0] {
        COIN_FOREIGN = 2'b00,
        COIN_RS5     = 2'b01,
        COIN_RS10    = 2'b10,
        COIN_RS20    = 2'b11
    } coin_code_t;

    // Product codes match the vending stage's encoding.
    typedef enum logic [1:0] {
        PROD_NONE  = 2'b00,
        PROD_NEWS  = 2'b01,
        PROD_CHOC  = 2'b10,
        PROD_JUICE = 2'b11
    } product_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        OFFER   = 2'b10,
        REFUND  = 2'b11
    } acc_state_t;

    localparam int RS5_VALUE  = 5;
    localparam int RS10_VALUE = 10;
    localparam int RS20_VALUE = 20;

    // Rupee value of a coin code; a foreign coin is worth nothing.
    function automatic int unsigned coin_value(input logic [1:0] code);
        int unsigned v;
        case (code)
            COIN_RS5:  v = RS5_VALUE;
            COIN_RS10: v = RS10_VALUE;
            COIN_RS20: v = RS20_VALUE;
            default:   v = 0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Load-clear idle counter. Counts while i_run is high and holds at the
// terminal value; o_expired flags the cycle the count reaches TIMEOUT_CYC-1.
module idle_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] r_count;

    // Count idle cycles; clear has priority and the count holds at expiry.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && !o_expired) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_expired = i_run && (r_count == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/coin_accumulator.sv
// Vending front-end: accepts coins and selections, accumulates credit, offers
// one vend request on a valid/ready handshake and refunds on cancel/timeout.
module coin_accumulator
    import vm_pkg::*;
#(
    parameter int MAX_CREDIT  = 20,
    parameter int TIMEOUT_CYC = 255,
    parameter int CW          = CW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          coin_valid,
    input  logic [1:0]    coin_code,
    input  logic          select_valid,
    input  logic [1:0]    select_product,
    input  logic          cancel,
    input  logic          vend_ready,
    output logic          vend_valid,
    output logic [CW-1:0] money,
    output logic [1:0]    product,
    output logic          change_valid,
    output logic [CW-1:0] change_amount,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic          busy
);

    acc_state_t    r_state, w_state_nx;
    logic [CW-1:0] r_credit, w_credit_nx;
    logic [CW-1:0] r_money, w_money_nx;
    logic [1:0]    r_product, w_product_nx;
    logic [CW-1:0] r_change_amount, w_change_amount_nx;
    logic          r_change_valid, w_change_valid_nx;
    logic          r_coin_reject, w_coin_reject_nx;
    logic          r_vend_valid, r_busy;

    logic [CW:0]   w_sum;
    logic          w_coin_ok, w_coin_accept, w_select_ok;
    logic          w_expired, w_timer_clear, w_timer_run;

    // One extra bit on the sum so the cap check can never be fooled by wrap.
    assign w_sum       = {1'b0, r_credit} + (CW+1)'(coin_value(coin_code));
    assign w_coin_ok   = coin_valid && (coin_code != COIN_FOREIGN) &&
                         (w_sum <= (CW+1)'(MAX_CREDIT));
    assign w_select_ok = select_valid && (select_product != PROD_NONE);

    assign w_timer_run   = (r_state == COLLECT);
    assign w_timer_clear = w_coin_accept || (r_state != COLLECT);

    idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_run     (w_timer_run),
        .o_expired (w_expired)
    );

    // Next-state and next-output decode; cancel/timeout beat coins, coins beat select.
    // NOTE: every signal is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nx         = r_state;
        w_credit_nx        = r_credit;
        w_money_nx         = r_money;
        w_product_nx       = r_product;
        w_change_valid_nx  = 1'b0;
        w_change_amount_nx = '0;
        w_coin_reject_nx   = 1'b0;
        w_coin_accept      = 1'b0;

        case (r_state)
            IDLE: begin
                if (coin_valid) begin
                    if (w_coin_ok) begin
                        w_coin_accept = 1'b1;
                        w_credit_nx   = w_sum[CW-1:0];
                        w_state_nx    = COLLECT;
                    end else begin
                        w_coin_reject_nx = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (cancel || w_expired) begin
                    // A coin arriving with cancel is returned; refund is the old credit.
                    w_state_nx         = REFUND;
                    w_change_valid_nx  = 1'b1;
                    w_change_amount_nx = r_credit;
                    w_coin_reject_nx   = coin_valid;
                end else begin
                    if (coin_valid) begin
                        if (w_coin_ok) begin
                            w_coin_accept = 1'b1;
                            w_credit_nx   = w_sum[CW-1:0];
                        end else begin
                            w_coin_reject_nx = 1'b1;
                        end
                    end
                    // A select coinciding with an accepted coin is dropped.
                    if (w_select_ok && !w_coin_accept) begin
                        w_state_nx   = OFFER;
                        w_money_nx   = r_credit;
                        w_product_nx = select_product;
                    end
                end
            end
            OFFER: begin
                w_coin_reject_nx = coin_valid;
                if (vend_ready) begin
                    w_state_nx   = IDLE;
                    w_credit_nx  = '0;
                    w_money_nx   = '0;
                    w_product_nx = '0;
                end
            end
            REFUND: begin
                w_coin_reject_nx = coin_valid;
                w_state_nx       = IDLE;
                w_credit_nx      = '0;
            end
            default: begin
                w_state_nx  = IDLE;
                w_credit_nx = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops any pending vend or refund.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_credit        <= '0;
            r_money         <= '0;
            r_product       <= '0;
            r_change_valid  <= 1'b0;
            r_change_amount <= '0;
            r_coin_reject   <= 1'b0;
            r_vend_valid    <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_credit        <= w_credit_nx;
            r_money         <= w_money_nx;
            r_product       <= w_product_nx;
            r_change_valid  <= w_change_valid_nx;
            r_change_amount <= w_change_amount_nx;
            r_coin_reject   <= w_coin_reject_nx;
            r_vend_valid    <= (w_state_nx == OFFER);
            r_busy          <= (w_state_nx == OFFER) || (w_state_nx == REFUND);
        end
    end

    assign vend_valid    = r_vend_valid;
    assign money         = r_money;
    assign product       = r_product;
    assign change_valid  = r_change_valid;
    assign change_amount = r_change_amount;
    assign coin_reject   = r_coin_reject;
    assign credit        = r_credit;
    assign busy          = r_busy;

endmodule

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
Upstream front-end of the vending machine FSM. Accepts coin insertions and product selections, accumulates credit, and presents one vend request (money, product) on a valid/ready handshake to the vending stage. Returns unspent credit as change on cancel or idle timeout. Rejects coins that would exceed the credit cap, or that arrive while a request is pending.

Parameters:
MAX_CREDIT, 20, credit cap in rupees; a coin pushing credit above this is rejected
TIMEOUT_CYC, 255, idle cycles in COLLECT before automatic refund
CW, 5, credit/money width in bits

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
coin_valid  input  1  one-cycle strobe, coin present on coin_code
coin_code  input  2  01=Rs5, 10=Rs10, 11=Rs20, 00=foreign coin (always rejected)
select_valid  input  1  one-cycle strobe, product on select_product
select_product  input  2  01=news, 10=choc, 11=juice, 00=ignored
cancel  input  1  one-cycle strobe, request refund
vend_ready  input  1  downstream accepts request
vend_valid  output  1  request pending
money  output  CW  credit offered with request
product  output  2  latched product code
change_valid  output  1  one-cycle change pulse
change_amount  output  CW  refunded amount, valid with change_valid
coin_reject  output  1  one-cycle pulse, coin returned
credit  output  CW  current accumulated credit
busy  output  1  high in OFFER or REFUND

Behaviour:
- All outputs registered. Reset (reset=0, asynchronous): state=IDLE, credit=0, all outputs 0, timer=0.
- States: IDLE (credit=0), COLLECT (credit>0), OFFER (vend_valid=1), REFUND (one cycle).
- Coin accept: coin_valid, legal code, state IDLE/COLLECT, credit+value<=MAX_CREDIT -> credit updates at that edge. IDLE->COLLECT. Timer cleared.
- Coin reject: code 00, overflow, or state OFFER/REFUND -> coin_reject=1 for the cycle after the edge; credit unchanged.
- Select: select_valid, code!=00, state COLLECT -> product latched, money=credit, ->OFFER at that edge. Select in IDLE or with code 00 is ignored.
- OFFER: vend_valid, money and product stay stable until vend_ready=1 at a rising edge. On that edge: credit=0, vend_valid=0, ->IDLE. No refund here; the vending stage owns balance return. cancel and select are ignored in OFFER.
- Cancel in COLLECT -> REFUND. Cancel in IDLE is ignored.
- REFUND: change_valid=1 and change_amount=credit for exactly one cycle. Credit is cleared at the next edge. ->IDLE.
- Timer: counts in COLLECT only and is cleared on each accepted coin. Reaching TIMEOUT_CYC-1 -> REFUND on the next edge.
- Same-cycle priority in COLLECT: cancel > coin > select.
  - cancel+coin: coin rejected, refund is the old credit.
  - coin+select: coin accepted, select dropped and must be reasserted.
- Credit never exceeds MAX_CREDIT. No arithmetic wrap is possible; the overflow check uses a CW+1-bit sum.
- Reset asserted mid-OFFER/REFUND: credit is lost, and no change or vend is emitted.

Decomposition:
- Package vm_pkg holds:
  - coin codes and their values (5/10/20);
  - product codes (matching the vending stage's 01/10/11);
  - state enum IDLE/COLLECT/OFFER/REFUND;
  - the CW default.
- One sub-module, idle_timer: load-clear counter with an expiry flag, parameterised by TIMEOUT_CYC.

Test Plan:
- Reset, then Rs10 then Rs5, select choc -> credit 10 then 15; vend_valid=1, money=15, product=10. Hold vend_ready=0 for 3 cycles -> outputs stable. vend_ready=1 -> credit=0, back to IDLE.
- Rs20 then Rs5 -> second coin gets a coin_reject pulse, credit stays 20. coin_code 00 -> coin_reject, credit unchanged.
- Rs5, Rs10, cancel -> change_valid one cycle with change_amount=15, credit=0, state IDLE.
- Rs5, then TIMEOUT_CYC idle cycles -> change_valid with change_amount=5 at the expiry edge+1. A coin inserted at cycle 200 restarts the count.
- Rs5 then coin+select in the same cycle -> coin accepted (credit 10), no vend_valid. Select next cycle -> money=10. cancel+coin in the same cycle -> coin_reject plus refund of the old credit.
- Pull reset low during OFFER with money=15 -> all outputs 0 immediately (asynchronous), no change_valid; after release, state IDLE.
